// File: rtl/mod_crit_latch_bank.sv
// Multi-channel latch bank: words stay frozen while crit is high, and writes made during the window are committed together when it closes.
// Optional hold-timeout watchdog is built when CRIT_LATCH_TIMEOUT_EN is defined.

module critLatchLane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             directWr,
    input  logic             shadowWr,
    input  logic             commit,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] word,
    output logic             pend,
    output logic             overHit
);
    logic [WIDTH-1:0] shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word   <= '0;
            shadow <= '0;
            pend   <= 1'b0;
        end else begin
            // A direct write in the commit cycle is newer than the shadow, so it wins
            if (directWr)
                word <= wrData;
            else if (commit && pend)
                word <= shadow;
            if (shadowWr)
                shadow <= wrData;
            if (commit)
                pend <= 1'b0;
            else if (shadowWr)
                pend <= 1'b1;
        end
    end

    assign overHit = shadowWr & pend;
endmodule

module mod_crit_latch_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int HOLD_MAX = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        crit,
    input  logic                        wr_en,
    input  logic [$clog2(CHANNELS)-1:0] wr_sel,
    input  logic [WIDTH-1:0]            wr_data,
    output logic [CHANNELS*WIDTH-1:0]   dataOut,
    output logic [CHANNELS-1:0]         pending,
    output logic                        overflow,
    output logic                        timeout
);
    localparam int SW = $clog2(CHANNELS);
    localparam logic [SW:0] CH_LIM = CHANNELS[SW:0];

    localparam logic [1:0] OPEN   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    typedef struct packed {
        logic             en;
        logic [SW-1:0]    sel;
        logic [WIDTH-1:0] data;
    } wrReq_t;

    wrReq_t req;
    logic   selOk;
    logic   forceCommit;
    logic [1:0] state, nextState;
    logic [CHANNELS-1:0][WIDTH-1:0] words;
    logic [CHANNELS-1:0] selHit, overHit;

    assign req   = {wr_en, wr_sel, wr_data};
    assign selOk = req.en && ({1'b0, req.sel} < CH_LIM);

    always_comb begin
        nextState = state;
        case (state)
            OPEN:    nextState = crit ? HOLD : OPEN;
            HOLD:    nextState = (!crit || forceCommit) ? COMMIT : HOLD;
            COMMIT:  nextState = crit ? HOLD : OPEN;
            default: nextState = OPEN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= OPEN;
        else
            state <= nextState;
    end

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : gLane
            localparam logic [SW-1:0] IDX = SW'(i);
            assign selHit[i] = selOk && (req.sel == IDX);
            critLatchLane #(.WIDTH(WIDTH)) uLane (
                .clk      (clk),
                .rst      (rst),
                .directWr (selHit[i] && (state != HOLD)),
                .shadowWr (selHit[i] && (state == HOLD)),
                .commit   (state == COMMIT),
                .wrData   (req.data),
                .word     (words[i]),
                .pend     (pending[i]),
                .overHit  (overHit[i])
            );
        end
    endgenerate

    assign dataOut = words;

    // Flags survive a forced commit that re-enters HOLD; only a real return to OPEN clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (state == COMMIT && nextState == OPEN)
            overflow <= 1'b0;
        else if (|overHit)
            overflow <= 1'b1;
    end

`ifdef CRIT_LATCH_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HMAX = HOLD_MAX[CW-1:0];

    logic [CW-1:0] holdCnt, holdNext;

    assign holdNext    = holdCnt + 1'b1;
    assign forceCommit = (state == HOLD) && (holdNext == HMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            holdCnt <= '0;
        else if (state == HOLD && !forceCommit)
            holdCnt <= holdNext;
        else
            holdCnt <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout <= 1'b0;
        else if (state == COMMIT && nextState == OPEN)
            timeout <= 1'b0;
        else if (forceCommit)
            timeout <= 1'b1;
    end
`else
    assign forceCommit = 1'b0;
    // Without the watchdog HOLD_MAX has no effect; this folds to a constant 0
    assign timeout     = (HOLD_MAX < 1);
`endif
endmodule

// File: doc/mod_crit_latch_bank.md
# mod_crit_latch_bank

Multi-channel, clocked successor to the single-bit D latch. It holds CHANNELS words of WIDTH bits that are transparent to writes while `crit` is low and frozen while `crit` is high. Writes arriving during a critical window are buffered in per-channel shadow registers and committed atomically when the window closes. It sits between the neuron/gait update logic and the servo/actuator consumers, so those consumers never see a partially updated set of outputs.

## Interface
Parameters:
- WIDTH, 8, bits per channel word
- CHANNELS, 4, number of channels (≥2)
- HOLD_MAX, 255, hold-cycle limit for the timeout feature (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- crit  in  1  critical window; high = outputs frozen
- wr_en  in  1  write strobe, one word per cycle
- wr_sel  in  $clog2(CHANNELS)  target channel
- wr_data  in  WIDTH  write data
- dataOut  out  CHANNELS*WIDTH  held words; channel i at bits [i*WIDTH +: WIDTH]
- pending  out  CHANNELS  shadow holds an uncommitted word, one bit per channel
- overflow  out  1  sticky; a pending shadow was overwritten
- timeout  out  1  sticky; hold exceeded HOLD_MAX

## Operation
- One clock domain. Reset is asynchronous and active-high.
- Reset values:
  - dataOut = 0, pending = 0, overflow = 0, timeout = 0
  - shadows = 0, hold counter = 0, state = OPEN
- FSM states: OPEN, HOLD, COMMIT.
  - OPEN: a write with wr_en=1 loads dataOut[wr_sel] directly. crit=1 sampled → HOLD.
  - HOLD: dataOut is frozen. A write loads shadow[wr_sel] and sets pending[wr_sel]. If pending[wr_sel] was already 1, the shadow is overwritten (last write wins) and overflow is set. crit=0 sampled → COMMIT.
  - COMMIT: for every channel with pending=1, dataOut ← shadow, then pending is cleared.
    - A write in this cycle goes directly to dataOut[wr_sel] and beats that channel's shadow.
    - Next state is HOLD if crit=1, otherwise OPEN.
- wr_sel ≥ CHANNELS: the write is ignored, with no flag change.
- overflow and timeout clear only on the COMMIT→OPEN transition or on rst.
- Channels without a pending bit are untouched by COMMIT.

## Timing
- OPEN write: dataOut changes at the edge that samples wr_en. Latency is 1 cycle.
- crit rising: the edge that samples crit=1 in OPEN still performs that cycle's write directly, then enters HOLD. Writes from the next cycle on are shadowed.
- crit falling: edge k samples crit=0 in HOLD → COMMIT. Edge k+1 updates dataOut with all pending words simultaneously and clears pending. Worst-case latency is 2 edges.
- pending is visible 1 cycle after a HOLD write.
- Reset asserted mid-HOLD or mid-COMMIT discards all shadows. Outputs return to reset values immediately, not at a clock edge.
- Simultaneous HOLD write to a channel that is pending while crit drops: the write lands in the shadow and is committed in the following COMMIT.

## Configuration
- Macro: CRIT_LATCH_TIMEOUT_EN.
- Defined:
  - A hold counter increments every HOLD cycle and clears in OPEN/COMMIT.
  - When the counter reaches HOLD_MAX, timeout is set and a forced COMMIT occurs even though crit is high.
  - After a forced COMMIT the FSM returns to HOLD with the counter cleared.
- Undefined: no counter exists, timeout is tied to 0, and HOLD persists indefinitely while crit=1.

## Test plan
- Reset: assert rst asynchronously mid-cycle → dataOut=0, pending=0, overflow=0, timeout=0 immediately.
- OPEN write: crit=0, write ch2=0xA5 → dataOut[23:16]=0xA5 after 1 edge, pending=0.
- Hold/commit, WIDTH=8, CHANNELS=4:
  - crit=1, then write ch0=0x11 and ch3=0x33 → dataOut unchanged, pending=4'b1001.
  - crit=0 → 2 edges later dataOut ch0=0x11, ch3=0x33 together, pending=0.
- Overflow: in HOLD write ch1=0x01, then ch1=0x02 → overflow=1. Commit gives ch1=0x02. overflow clears on return to OPEN.
- COMMIT collision: in the COMMIT cycle write ch0=0x77 while shadow ch0=0x11 → ch0=0x77. Out-of-range wr_sel leaves all outputs unchanged.
- Timeout, CRIT_LATCH_TIMEOUT_EN defined, HOLD_MAX=4:
  - Hold crit=1 with ch0 pending → forced commit after 4 HOLD cycles and timeout=1.
  - Macro undefined: no commit while crit=1, timeout=0.
